dual_grant_arbiter: RTL

- Round-robin arbiter sharing two identical resource channels (A, B) among 12 requesters.
- Each cycle it picks the first and second eligible requesters from a rotating priority pointer, which is a dual priority encode, and holds each grant until that channel is released.
- Sits between the request lines of client blocks and a pair of shared datapath units.
- Grant IDs use the codebase's 1-based encoding: 1..12 names a requester, 0 means none.

---
 rtl/dual_grant_arbiter_if.sv | 36 +++
 rtl/dual_grant_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dual_grant_arbiter_if.sv
// Bundle between request-side clients and the dual-channel arbiter.
//
// Handshake: a client requests by holding its bit of req high. A grant is
// announced by gnt_x_vld with the owner's 1-based ID on gnt_x_id (0 = none),
// and stays valid for as long as the channel is BUSY, regardless of req.
// The owner ends its tenure with a single-cycle rel_x pulse. rel_x seen while
// the channel is idle has no effect. tmo_x is a single-cycle notice that the
// arbiter reclaimed the channel itself (watchdog builds only).
interface dual_grant_arbiter_if #(
    parameter int N_REQ = 12,
    parameter int ID_W  = 4
);
    logic [N_REQ-1:0] req;
    logic             rel_a;
    logic             rel_b;
    logic             gnt_a_vld;
    logic [ID_W-1:0]  gnt_a_id;
    logic             gnt_b_vld;
    logic [ID_W-1:0]  gnt_b_id;
    logic [N_REQ-1:0] gnt_vec;
    logic [ID_W-1:0]  ptr;
    logic             tmo_a;
    logic             tmo_b;

    // Client side: raises requests and release pulses, observes grants.
    modport master (
        output req, rel_a, rel_b,
        input  gnt_a_vld, gnt_a_id, gnt_b_vld, gnt_b_id, gnt_vec, ptr, tmo_a, tmo_b
    );

    // Arbiter side.
    modport slave (
        input  req, rel_a, rel_b,
        output gnt_a_vld, gnt_a_id, gnt_b_vld, gnt_b_id, gnt_vec, ptr, tmo_a, tmo_b
    );
endinterface

// File: rtl/dual_grant_arbiter.sv
// Round-robin arbiter handing two identical channels (A, B) to 12 requesters.
// A rotating pointer picks the first and second eligible requesters each
// cycle; a grant is held until its owner pulses rel_x.
// Optional build macro DGA_TIMEOUT_EN adds a per-channel busy watchdog that
// reclaims a channel after TIMEOUT_CYCLES busy cycles and pulses tmo_x.
// Channel FSM state is visible externally as gnt_a_vld / gnt_b_vld (BUSY=1).
module dual_grant_arbiter #(
    parameter int N_REQ          = 12,
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_grant_arbiter_if.slave   bus
);

    // The wrap arithmetic and ID encoding assume exactly 12 requesters.
    if (N_REQ != 12) begin : g_bad_nreq
        $error("dual_grant_arbiter: N_REQ must be 12");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("dual_grant_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ch_state_e;

    ch_state_e        st_a, st_b, nxt_st_a, nxt_st_b;
    logic [ID_W-1:0]  nxt_id_a, nxt_id_b, nxt_ptr;
    logic             nxt_tmo_a, nxt_tmo_b;
    logic [N_REQ-1:0] held_mask, elig;
    logic             found1, found2;
    logic [ID_W-1:0]  first_idx, second_idx;
    logic [ID_W:0]    scan_pos;
    logic [ID_W-1:0]  scan_idx;
    logic             tmo_hit_a, tmo_hit_b;

    // 1-based ID to one-hot requester vector; ID 0 maps to nothing.
    function automatic logic [N_REQ-1:0] id_to_vec(input logic [ID_W-1:0] id);
        id_to_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (id == ID_W'(i + 1)) id_to_vec[i] = 1'b1;
        end
    endfunction

    // Pointer successor, wrapping 11 -> 0.
    function automatic logic [ID_W-1:0] inc_ptr(input logic [ID_W-1:0] p);
        inc_ptr = (p == ID_W'(N_REQ - 1)) ? '0 : p + ID_W'(1);
    endfunction

`ifdef DGA_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    // Timeout fires on the edge that would bring the busy count to the limit,
    // unless the owner releases on that same edge.
    assign tmo_hit_a = (st_a == BUSY) && !bus.rel_a && (cnt_a == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_hit_b = (st_b == BUSY) && !bus.rel_b && (cnt_b == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_a = 1'b0;
    assign tmo_hit_b = 1'b0;
`endif

    // Eligible set and dual priority encode from the rotating pointer.
    always_comb begin
        held_mask = '0;
        if (st_a == BUSY) held_mask = held_mask | id_to_vec(bus.gnt_a_id);
        if (st_b == BUSY) held_mask = held_mask | id_to_vec(bus.gnt_b_id);
        elig       = bus.req & ~held_mask;
        found1     = 1'b0;
        found2     = 1'b0;
        first_idx  = '0;
        second_idx = '0;
        scan_pos   = '0;
        scan_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_pos = {1'b0, bus.ptr} + (ID_W + 1)'(k);
            if (scan_pos >= (ID_W + 1)'(N_REQ)) scan_pos = scan_pos - (ID_W + 1)'(N_REQ);
            scan_idx = scan_pos[ID_W-1:0];
            if (elig[scan_idx]) begin
                if (!found1) begin
                    found1    = 1'b1;
                    first_idx = scan_idx;
                end else if (!found2) begin
                    found2     = 1'b1;
                    second_idx = scan_idx;
                end
            end
        end
    end

    // Next-state for both channel FSMs: release/timeout, then grant of idle channels.
    always_comb begin
        nxt_st_a  = st_a;
        nxt_st_b  = st_b;
        nxt_id_a  = bus.gnt_a_id;
        nxt_id_b  = bus.gnt_b_id;
        nxt_ptr   = bus.ptr;
        nxt_tmo_a = 1'b0;
        nxt_tmo_b = 1'b0;

        if (st_a == BUSY && bus.rel_a) begin
            nxt_st_a = IDLE;
            nxt_id_a = '0;
        end else if (tmo_hit_a) begin
            nxt_st_a  = IDLE;
            nxt_id_a  = '0;
            nxt_tmo_a = 1'b1;
        end

        if (st_b == BUSY && bus.rel_b) begin
            nxt_st_b = IDLE;
            nxt_id_b = '0;
        end else if (tmo_hit_b) begin
            nxt_st_b  = IDLE;
            nxt_id_b  = '0;
            nxt_tmo_b = 1'b1;
        end

        // Only channels idle in the current cycle take part, so a released
        // channel sits idle for exactly one cycle before its next owner.
        if (st_a == IDLE && st_b == IDLE) begin
            if (found1) begin
                nxt_st_a = BUSY;
                nxt_id_a = first_idx + ID_W'(1);
                nxt_ptr  = inc_ptr(first_idx);
                if (found2) begin
                    nxt_st_b = BUSY;
                    nxt_id_b = second_idx + ID_W'(1);
                    nxt_ptr  = inc_ptr(second_idx);
                end
            end
        end else if (st_a == IDLE) begin
            if (found1) begin
                nxt_st_a = BUSY;
                nxt_id_a = first_idx + ID_W'(1);
                nxt_ptr  = inc_ptr(first_idx);
            end
        end else if (st_b == IDLE) begin
            if (found1) begin
                nxt_st_b = BUSY;
                nxt_id_b = first_idx + ID_W'(1);
                nxt_ptr  = inc_ptr(first_idx);
            end
        end
    end

    // Channel state, registered outputs and (optionally) busy counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_a          <= IDLE;
            st_b          <= IDLE;
            bus.gnt_a_vld <= 1'b0;
            bus.gnt_a_id  <= '0;
            bus.gnt_b_vld <= 1'b0;
            bus.gnt_b_id  <= '0;
            bus.gnt_vec   <= '0;
            bus.ptr       <= '0;
            bus.tmo_a     <= 1'b0;
            bus.tmo_b     <= 1'b0;
`ifdef DGA_TIMEOUT_EN
            cnt_a         <= '0;
            cnt_b         <= '0;
`endif
        end else begin
            st_a          <= nxt_st_a;
            st_b          <= nxt_st_b;
            bus.gnt_a_vld <= (nxt_st_a == BUSY);
            bus.gnt_a_id  <= nxt_id_a;
            bus.gnt_b_vld <= (nxt_st_b == BUSY);
            bus.gnt_b_id  <= nxt_id_b;
            bus.gnt_vec   <= id_to_vec(nxt_id_a) | id_to_vec(nxt_id_b);
            bus.ptr       <= nxt_ptr;
            bus.tmo_a     <= nxt_tmo_a;
            bus.tmo_b     <= nxt_tmo_b;
`ifdef DGA_TIMEOUT_EN
            if (st_a == IDLE)      cnt_a <= '0;
            else                   cnt_a <= cnt_a + CNT_W'(1);
            if (st_b == IDLE)      cnt_b <= '0;
            else                   cnt_b <= cnt_b + CNT_W'(1);
`endif
        end
    end

endmodule
